s_axis_cc_adapt: RTL and testbench

Completer-completion adapter for the x4 128-bit UltraScale PHY path. Accepts LitePCIe legacy-format completion TLPs (3DW PCIe header plus payload, 128-bit, byte keep) and re-emits them as UltraScale CC AXIS packets (3DW CC descriptor plus payload, dword keep). It is the transmit counterpart of the CQ adapter and sits between the LitePCIe completion path and the PCIe IP s_axis_cc port. Header remap happens in place; both formats carry DW3 of beat 0 as the first payload DW.

---
 rtl/s_axis_cc_adapt.sv | 182 ++++++++++++++++++
 tb/tb_s_axis_cc_adapt.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axis_cc_adapt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : s_axis_cc_adapt
//  Purpose  : Completer-completion adapter. Converts legacy 3DW completion
//             TLPs (128-bit, byte keep) into CC AXIS packets (3DW CC
//             descriptor, dword keep) with a 2-entry skid output stage and
//             a length check against the header Length field.
//  Revision : 1.0 - initial release
// ============================================================================
module s_axis_cc_adapt #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
    input  logic                  s_axis_cc_tlast,
    input  logic                  s_axis_cc_tvalid,
    output logic                  s_axis_cc_tready,
    output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
    output logic [3:0]            s_axis_cc_tkeep_a,
    output logic                  s_axis_cc_tlast_a,
    output logic [32:0]           s_axis_cc_tuser_a,
    output logic                  s_axis_cc_tvalid_a,
    input  logic [3:0]            s_axis_cc_tready_a,
    output logic                  cc_len_err
);

    localparam logic [3:0] c_nodata_keep = 4'b0111;

    typedef enum logic [0:0] {
        ST_SOP  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            keep;
        logic                  last;
        logic                  err;
    } beat_t;

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        len_err_q, len_err_d;
    beat_t       main_q, main_d, skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;

    logic        w_in_fire;
    logic        w_out_ready;
    logic        w_has_data;
    logic [9:0]  w_len;
    logic [10:0] w_dwords;
    logic [10:0] w_sum;
    logic [8:0]  w_sop_cnt;
    logic [11:0] w_bytecount;
    logic [12:0] w_bc13;
    logic [10:0] w_dw_count;
    logic [31:0] w_desc0, w_desc1, w_desc2;
    logic [3:0]  w_keep_map;
    beat_t       w_beat;

    assign w_in_fire   = s_axis_cc_tvalid && s_axis_cc_tready;
    assign w_out_ready = s_axis_cc_tready_a[0];

    // Legacy header fields (valid on the SOP beat only)
    assign w_has_data  = s_axis_cc_tdata[30];
    assign w_len       = s_axis_cc_tdata[9:0];
    assign w_dwords    = (w_len == 10'd0) ? 11'd1024 : {1'b0, w_len};
    // Beats after the SOP beat: ceil((dwords-1)/4) == (dwords+2)/4
    assign w_sum       = w_dwords + 11'd2;
    assign w_sop_cnt   = w_has_data ? w_sum[10:2] : 9'd0;
    assign w_bytecount = s_axis_cc_tdata[43:32];
    assign w_bc13      = (w_bytecount == 12'd0) ? 13'h1000 : {1'b0, w_bytecount};
    assign w_dw_count  = w_has_data ? w_dwords : 11'd0;

    // CC descriptor DW0..DW2
    assign w_desc0 = {3'b000, w_bc13, 6'b0, 2'b00, 1'b0, s_axis_cc_tdata[70:64]};
    assign w_desc1 = {s_axis_cc_tdata[95:80], 1'b0, s_axis_cc_tdata[14],
                      s_axis_cc_tdata[47:45], w_dw_count};
    assign w_desc2 = {1'b0, 1'b0, s_axis_cc_tdata[13:12], s_axis_cc_tdata[22:20],
                      1'b0, s_axis_cc_tdata[63:48], s_axis_cc_tdata[79:72]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_keep_map
        assign w_keep_map[gi] = s_axis_cc_tkeep[4*gi];
    end

    // Beat formatting, length check and SOP/DATA sequencing
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_beat    = '0;
        len_err_d = 1'b0;

        w_beat.last = s_axis_cc_tlast;
        if (state_q == ST_SOP) begin
            w_beat.data = {s_axis_cc_tdata[127:96], w_desc2, w_desc1, w_desc0};
            w_beat.keep = w_has_data ? w_keep_map : c_nodata_keep;
            w_beat.err  = s_axis_cc_tlast && (w_sop_cnt != 9'd0);
        end else begin
            w_beat.data = s_axis_cc_tdata;
            w_beat.keep = w_keep_map;
            w_beat.err  = s_axis_cc_tlast && (cnt_q != 9'd1);
        end

        if (w_in_fire) begin
            len_err_d = w_beat.err;
            if (state_q == ST_SOP) begin
                cnt_d   = s_axis_cc_tlast ? 9'd0 : w_sop_cnt;
                state_d = s_axis_cc_tlast ? ST_SOP : ST_DATA;
            end else begin
                // Saturate at 0 so an overlong packet is flagged at its tlast
                cnt_d   = (cnt_q != 9'd0) ? cnt_q - 9'd1 : 9'd0;
                state_d = s_axis_cc_tlast ? ST_SOP : ST_DATA;
            end
        end
    end

    // Two-entry skid buffer: main drives the outputs, skid catches a stalled beat
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (!main_valid_q || w_out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = w_in_fire;
                if (w_in_fire) begin
                    main_d = w_beat;
                end
            end
        end else if (w_in_fire) begin
            skid_d       = w_beat;
            skid_valid_d = 1'b1;
        end
    end

    // State, counter, error pulse and buffer registers
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q      <= ST_SOP;
            cnt_q        <= 9'd0;
            len_err_q    <= 1'b0;
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_err_q    <= len_err_d;
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign s_axis_cc_tready   = !skid_valid_q;
    assign s_axis_cc_tdata_a  = main_q.data;
    assign s_axis_cc_tkeep_a  = main_q.keep;
    assign s_axis_cc_tlast_a  = main_q.last;
    assign s_axis_cc_tuser_a  = {32'd0, main_q.err};
    assign s_axis_cc_tvalid_a = main_valid_q;
    assign cc_len_err         = len_err_q;

    // Inputs that carry no information for this datapath
    logic unused_bits;
    assign unused_bits = ^{s_axis_cc_tready_a[3:1], s_axis_cc_tkeep[15:13],
                           s_axis_cc_tkeep[11:9], s_axis_cc_tkeep[7:5],
                           s_axis_cc_tkeep[3:1], w_sum[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_s_axis_cc_adapt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_s_axis_cc_adapt
//  Purpose  : Self-checking bench for s_axis_cc_adapt using a packet-level
//             reference model and directed completion traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_s_axis_cc_adapt;

    logic         user_clk = 1'b0;
    logic         user_reset_n;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic [127:0] tdata_a;
    logic [3:0]   tkeep_a;
    logic         tlast_a;
    logic [32:0]  tuser_a;
    logic         tvalid_a;
    logic [3:0]   tready_a;
    logic         cc_len_err;
    logic         rdy;

    assign tready_a = {3'b101, rdy};

    s_axis_cc_adapt #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) dut (
        .user_clk           (user_clk),
        .user_reset_n       (user_reset_n),
        .s_axis_cc_tdata    (s_tdata),
        .s_axis_cc_tkeep    (s_tkeep),
        .s_axis_cc_tlast    (s_tlast),
        .s_axis_cc_tvalid   (s_tvalid),
        .s_axis_cc_tready   (s_tready),
        .s_axis_cc_tdata_a  (tdata_a),
        .s_axis_cc_tkeep_a  (tkeep_a),
        .s_axis_cc_tlast_a  (tlast_a),
        .s_axis_cc_tuser_a  (tuser_a),
        .s_axis_cc_tvalid_a (tvalid_a),
        .s_axis_cc_tready_a (tready_a),
        .cc_len_err         (cc_len_err)
    );

    always #5 user_clk = ~user_clk;

    int n_chk = 0;
    int n_err = 0;
    int err_pulses = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: packet-level view of the conversion
    // ------------------------------------------------------------------
    typedef struct {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
        logic         e;
        int           pkt;
        bit           sop;
    } exp_t;

    exp_t         expq[$];
    exp_t         x;
    exp_t         y;
    bit           m_sop = 1'b1;
    int           m_idx = 0;
    int           m_total = 1;
    int           m_pkt = -1;
    int           occ = 0;
    bit           err_pend = 1'b0;
    bit           acc;
    bit           drain;
    logic [127:0] snap_d [16];
    logic [3:0]   snap_k [16];

    function automatic logic [127:0] build_hdr(input logic [127:0] d);
        logic [2:0]  fmt;
        int          dw;
        int          bcv;
        logic [31:0] o0, o1, o2;
        fmt = d[31:29];
        dw  = fmt[1] ? ((d[9:0] == 10'd0) ? 1024 : int'(d[9:0])) : 0;
        bcv = (d[43:32] == 12'd0) ? 4096 : int'(d[43:32]);
        o0  = (32'(bcv) << 16) | 32'(d[70:64]);
        o1  = (32'(d[95:80]) << 16) | (32'(d[14]) << 14) | (32'(d[47:45]) << 11) | 32'(dw);
        o2  = (32'(d[13:12]) << 28) | (32'(d[22:20]) << 25) | (32'(d[63:48]) << 8) | 32'(d[79:72]);
        return {d[127:96], o2, o1, o0};
    endfunction

    function automatic int beats_for(input logic [127:0] d);
        int dw;
        if (!d[30]) return 1;
        dw = (d[9:0] == 10'd0) ? 1024 : int'(d[9:0]);
        return 1 + (dw - 1 + 3) / 4;
    endfunction

    function automatic logic [3:0] kmap(input logic [15:0] k);
        return {k[12], k[8], k[4], k[0]};
    endfunction

    // Per-cycle comparison against the model
    always @(negedge user_clk) begin
        if (!user_reset_n) begin
            expq.delete();
            occ      = 0;
            m_sop    = 1'b1;
            err_pend = 1'b0;
        end else begin
            acc   = s_tvalid && s_tready;
            drain = tvalid_a && tready_a[0];
            chk("tvalid_a", 128'(tvalid_a), 128'(occ > 0));
            chk("s_tready", 128'(s_tready), 128'(occ < 2));
            chk("cc_len_err", 128'(cc_len_err), 128'(err_pend));
            if (cc_len_err) err_pulses++;
            if (drain) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected none", tdata_a);
                end else begin
                    y = expq.pop_front();
                    chk("tdata_a", tdata_a, y.d);
                    chk("tkeep_a", 128'(tkeep_a), 128'(y.k));
                    chk("tlast_a", 128'(tlast_a), 128'(y.l));
                    chk("tuser_a", 128'(tuser_a), 128'(y.e));
                    if (y.sop && y.pkt >= 0 && y.pkt < 16) begin
                        snap_d[y.pkt] = tdata_a;
                        snap_k[y.pkt] = tkeep_a;
                    end
                end
            end
            err_pend = 1'b0;
            if (acc) begin
                if (m_sop) begin
                    m_pkt++;
                    m_idx   = 0;
                    m_total = beats_for(s_tdata);
                    x.d     = build_hdr(s_tdata);
                    x.k     = s_tdata[30] ? kmap(s_tkeep) : 4'b0111;
                end else begin
                    x.d = s_tdata;
                    x.k = kmap(s_tkeep);
                end
                x.l   = s_tlast;
                x.e   = s_tlast && (m_idx + 1 != m_total);
                x.pkt = m_pkt;
                x.sop = m_sop;
                expq.push_back(x);
                err_pend = x.e;
                m_idx++;
                m_sop = s_tlast;
            end
            occ = occ + int'(acc) - int'(drain);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [127:0] make_beat(input logic [9:0] len, input logic [7:0] tag, input int i);
        logic [31:0] dw0, dw1, dw2, dw3;
        int          dws;
        logic [11:0] bc;
        if (i == 0) begin
            dws = (len == 10'd0) ? 1024 : int'(len);
            bc  = 12'(dws * 4);
            dw0 = 32'h4000_0000 | (32'(tag[2:0]) << 20) | (32'(tag[0]) << 14)
                | (32'(tag[1:0]) << 12) | 32'(len);
            dw1 = {16'hA500 | 16'(tag), tag[5:3], 1'b0, bc};
            dw2 = {16'h0100, tag, 1'b0, tag[6:0]};
            dw3 = 32'hD0D0_0000 | 32'(tag);
            return {dw3, dw2, dw1, dw0};
        end
        return {32'(i), 32'hCAFE_0000 | 32'(tag), 32'(i) ^ 32'h5A5A_5A5A, 32'hDA7A_0000 + 32'(i)};
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        int w;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        w = 0;
        @(negedge user_clk);
        while (!s_tready && w < 200) begin
            w++;
            @(negedge user_clk);
        end
        if (w >= 200) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: got tready=0 expected tready=1 within 200 cycles");
        end
        @(posedge user_clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_cpld(input logic [9:0] len, input int nbeats, input logic [7:0] tag,
                             input logic [15:0] last_keep);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(make_beat(len, tag, i), (i == nbeats - 1) ? last_keep : 16'hFFFF,
                      i == nbeats - 1);
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((occ != 0 || expq.size() != 0) && w < 100) begin
            w++;
            @(posedge user_clk);
            #1;
        end
        n_chk++;
        if (w >= 100) begin
            n_err++;
            $display("FAIL drain_timeout: got occupancy %0d expected 0", occ);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        user_reset_n = 1'b0;
        s_tvalid     = 1'b0;
        s_tdata      = '0;
        s_tkeep      = '0;
        s_tlast      = 1'b0;
        rdy          = 1'b1;
        for (int i = 0; i < 16; i++) begin
            snap_d[i] = '0;
            snap_k[i] = '0;
        end
        repeat (3) @(posedge user_clk);
        #1;
        chk("rst_tvalid_a", 128'(tvalid_a), 128'd0);
        chk("rst_tready", 128'(s_tready), 128'd1);
        chk("rst_tdata_a", tdata_a, 128'd0);
        chk("rst_tuser_a", 128'(tuser_a), 128'd0);
        user_reset_n = 1'b1;
        @(posedge user_clk);
        #1;

        // Single-beat CplD
        send_beat({32'hDEAD_BEEF, 32'h0100_2A10, 32'h0000_0004, 32'h4000_0001}, 16'hFFFF, 1'b1);
        // Completion without data, status UR, bytecount 0
        send_beat({32'h1234_5678, 32'h0000_0000, 32'h0000_2000, 32'h0000_0000}, 16'h0FFF, 1'b1);
        wait_drain();

        // 3-beat CplD with output back-pressure 1,0,0,1
        fork
            send_cpld(10'd8, 3, 8'h30, 16'h00FF);
            begin
                rdy = 1'b1;
                @(posedge user_clk); #1; rdy = 1'b0;
                @(posedge user_clk); #1; rdy = 1'b0;
                @(posedge user_clk); #1; rdy = 1'b1;
            end
        join
        wait_drain();

        // Early tlast, then a clean packet
        send_cpld(10'd8, 2, 8'h31, 16'h0FFF);
        send_cpld(10'd1, 1, 8'h32, 16'hFFFF);
        // Late tlast: len 4 expects 2 beats, 3 sent
        send_cpld(10'd4, 3, 8'h33, 16'h00FF);
        // Maximum length then a short packet back-to-back
        send_cpld(10'd0, 257, 8'h34, 16'hFFFF);
        send_cpld(10'd4, 2, 8'h35, 16'h000F);
        wait_drain();

        // Reset during beat 2 of a 3-beat packet
        send_beat(make_beat(10'd8, 8'h36, 0), 16'hFFFF, 1'b0);
        send_beat(make_beat(10'd8, 8'h36, 1), 16'hFFFF, 1'b0);
        s_tdata  = make_beat(10'd8, 8'h36, 2);
        s_tkeep  = 16'hFFFF;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        #2;
        user_reset_n = 1'b0;
        #1;
        chk("mid_rst_tvalid_a", 128'(tvalid_a), 128'd0);
        chk("mid_rst_tlast_a", 128'(tlast_a), 128'd0);
        chk("mid_rst_tkeep_a", 128'(tkeep_a), 128'd0);
        chk("mid_rst_tdata_a", tdata_a, 128'd0);
        chk("mid_rst_tuser_a", 128'(tuser_a), 128'd0);
        chk("mid_rst_len_err", 128'(cc_len_err), 128'd0);
        chk("mid_rst_tready", 128'(s_tready), 128'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(posedge user_clk);
        #1;
        user_reset_n = 1'b1;
        @(posedge user_clk);
        #1;
        send_cpld(10'd2, 2, 8'h37, 16'h00FF);
        wait_drain();

        // Hand-computed expectations that pin the model
        chk("lit_cpld_beat0", snap_d[0], 128'hDEADBEEF_0000002A_01000001_00040010);
        chk("lit_cpld_keep", 128'(snap_k[0]), 128'hF);
        chk("lit_nodata_dw0", 128'(snap_d[1][31:0]), 128'h1000_0000);
        chk("lit_nodata_dw1", 128'(snap_d[1][63:32]), 128'h0000_0800);
        chk("lit_nodata_keep", 128'(snap_k[1]), 128'h7);
        chk("lit_max_dwcount", 128'(snap_d[6][42:32]), 128'd1024);
        chk("lit_max_bytecount", 128'(snap_d[6][28:16]), 128'h1000);
        chk("lit_err_pulses", 128'(err_pulses), 128'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
